// File: rtl/pattern_stream_counter.sv
// Counts occurrences of a bit pattern across every word of a framed stream,
// including overlapping matches and matches straddling word boundaries.
module pattern_stream_counter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned PATTERN_WIDTH = 3,
   parameter int unsigned COUNT_WIDTH   = 16,
   parameter int unsigned WORDS_WIDTH   = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [PATTERN_WIDTH-1:0] Pattern,
   input  logic [DATA_WIDTH-1:0]    S_Data,
   input  logic                     S_Valid,
   input  logic                     S_Last,
   output logic                     S_Ready,
   output logic [COUNT_WIDTH-1:0]   M_Count,
   output logic [WORDS_WIDTH-1:0]   M_Words,
   output logic                     M_Overflow,
   output logic                     M_Valid,
   input  logic                     M_Ready
);

   localparam int unsigned EXT_W  = DATA_WIDTH + PATTERN_WIDTH - 1;
   localparam int unsigned TAIL_W = PATTERN_WIDTH - 1;
   localparam int unsigned BEAT_W = $clog2(DATA_WIDTH + 1);
   localparam int unsigned CSUM_W = ((COUNT_WIDTH > BEAT_W) ? COUNT_WIDTH : BEAT_W) + 1;
   localparam int unsigned WSUM_W = WORDS_WIDTH + 1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [WORDS_WIDTH-1:0] WORDS_MAX = '1;

   typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

   state_t                   state_q, state_d;
   logic [PATTERN_WIDTH-1:0] pat_q, pat_use;
   logic [TAIL_W-1:0]        tail_q;
   logic [EXT_W-1:0]         ext;
   logic [BEAT_W-1:0]        beat_cnt;
   logic                     accept, first;
   logic [COUNT_WIDTH-1:0]   count_base, count_d;
   logic [WORDS_WIDTH-1:0]   words_base, words_d;
   logic [CSUM_W-1:0]        count_sum;
   logic [WSUM_W-1:0]        words_sum;
   logic                     count_sat, words_sat, ovf_d;

   assign accept  = S_Valid & S_Ready;
   assign first   = (state_q == IDLE);
   assign pat_use = first ? Pattern : pat_q;
   assign ext     = {tail_q, S_Data};

   // Windows above DATA_WIDTH-1 reach into the previous word's tail bits.
   always_comb begin
      beat_cnt = '0;
      for (int unsigned i = PATTERN_WIDTH - 1; i < EXT_W; i++) begin
         if ((!first || i < DATA_WIDTH) && (ext[i -: PATTERN_WIDTH] == pat_use))
            beat_cnt = beat_cnt + BEAT_W'(1);
      end
   end

   // Saturating accumulation; a first word starts from zero.
   always_comb begin
      count_base = first ? '0 : M_Count;
      words_base = first ? '0 : M_Words;
      count_sum  = CSUM_W'(count_base) + CSUM_W'(beat_cnt);
      words_sum  = WSUM_W'(words_base) + WSUM_W'(1);
      count_sat  = (count_sum > CSUM_W'(COUNT_MAX));
      words_sat  = (words_sum > WSUM_W'(WORDS_MAX));
      count_d    = count_sat ? COUNT_MAX : count_sum[COUNT_WIDTH-1:0];
      words_d    = words_sat ? WORDS_MAX : words_sum[WORDS_WIDTH-1:0];
      ovf_d      = (first ? 1'b0 : M_Overflow) | count_sat | words_sat;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = S_Last ? RESULT : ACCUM;
         ACCUM:   if (accept && S_Last) state_d = RESULT;
         RESULT:  if (M_Valid && M_Ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q    <= IDLE;
         S_Ready    <= 1'b1;
         M_Valid    <= 1'b0;
         M_Count    <= '0;
         M_Words    <= '0;
         M_Overflow <= 1'b0;
         tail_q     <= '0;
         pat_q      <= '0;
      end else begin
         state_q <= state_d;
         S_Ready <= (state_d != RESULT);
         M_Valid <= (state_d == RESULT);
         if (accept) begin
            tail_q     <= S_Data[TAIL_W-1:0];
            M_Count    <= count_d;
            M_Words    <= words_d;
            M_Overflow <= ovf_d;
            if (first) pat_q <= Pattern;
         end
      end
   end

endmodule

// File: tb/tb_pattern_stream_counter.sv
// Bench for pattern_stream_counter: a wide-count and a narrow-count instance share
// stimulus and are checked against a bit-stream model of the whole frame.
module tb_pattern_stream_counter;

   localparam int unsigned DW  = 8;
   localparam int unsigned PW  = 3;
   localparam int unsigned CWA = 16;
   localparam int unsigned CWS = 3;
   localparam int unsigned WW  = 16;

   logic          Clk = 1'b0;
   logic          Rst;
   logic [PW-1:0] Pattern;
   logic [DW-1:0] S_Data;
   logic          S_Valid, S_Last, M_Ready;

   logic           s_ready_a, m_ovf_a, m_valid_a;
   logic [CWA-1:0] m_count_a;
   logic [WW-1:0]  m_words_a;
   logic           s_ready_s, m_ovf_s, m_valid_s;
   logic [CWS-1:0] m_count_s;
   logic [WW-1:0]  m_words_s;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_en = 0;

   always #5 Clk = ~Clk;

   pattern_stream_counter #(.DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .COUNT_WIDTH(CWA), .WORDS_WIDTH(WW)) dut_a (
      .Clk(Clk), .Rst(Rst), .Pattern(Pattern), .S_Data(S_Data), .S_Valid(S_Valid), .S_Last(S_Last),
      .S_Ready(s_ready_a), .M_Count(m_count_a), .M_Words(m_words_a), .M_Overflow(m_ovf_a),
      .M_Valid(m_valid_a), .M_Ready(M_Ready));

   pattern_stream_counter #(.DATA_WIDTH(DW), .PATTERN_WIDTH(PW), .COUNT_WIDTH(CWS), .WORDS_WIDTH(WW)) dut_s (
      .Clk(Clk), .Rst(Rst), .Pattern(Pattern), .S_Data(S_Data), .S_Valid(S_Valid), .S_Last(S_Last),
      .S_Ready(s_ready_s), .M_Count(m_count_s), .M_Words(m_words_s), .M_Overflow(m_ovf_s),
      .M_Valid(m_valid_s), .M_Ready(M_Ready));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the frame is kept as a flat bit stream and scanned once at Last.
   bit            q[$];
   logic [PW-1:0] mpat;
   int unsigned   mwords = 0;
   bit            pending = 0;
   bit            fresh = 0;
   int unsigned   raw_count = 0;
   int unsigned   raw_words = 0;

   function automatic int unsigned count_matches();
      int unsigned n = 0;
      for (int i = 0; i + int'(PW) <= q.size(); i++) begin
         bit hit = 1;
         for (int j = 0; j < int'(PW); j++)
            if (q[i+j] != mpat[int'(PW)-1-j]) hit = 0;
         if (hit) n++;
      end
      return n;
   endfunction

   always @(posedge Clk) begin
      if (Rst) begin
         q.delete(); pending = 0; fresh = 1; mwords = 0;
      end else if (pending) begin
         if (M_Ready) pending = 0;
      end else if (S_Valid) begin
         if (mwords == 0) mpat = Pattern;
         for (int b = int'(DW) - 1; b >= 0; b--) q.push_back(S_Data[b]);
         mwords++;
         fresh = 0;
         if (S_Last) begin
            raw_count = count_matches();
            raw_words = mwords;
            pending   = 1;
            q.delete();
            mwords    = 0;
         end
      end
   end

   function automatic longint unsigned sat(input int unsigned raw, input int unsigned w);
      longint unsigned mx = (64'd1 << w) - 1;
      return (raw > mx) ? mx : raw;
   endfunction

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("a_s_ready", s_ready_a, !pending);
         chk("a_m_valid", m_valid_a, pending);
         chk("s_s_ready", s_ready_s, !pending);
         chk("s_m_valid", m_valid_s, pending);
         if (fresh) begin
            chk("a_reset_count", m_count_a, 0);
            chk("a_reset_words", m_words_a, 0);
            chk("a_reset_ovf", m_ovf_a, 0);
            chk("s_reset_count", m_count_s, 0);
         end else if (pending) begin
            chk("a_count", m_count_a, sat(raw_count, CWA));
            chk("a_words", m_words_a, sat(raw_words, WW));
            chk("a_ovf", m_ovf_a, (raw_count > (2**CWA - 1)) || (raw_words > (2**WW - 1)));
            chk("s_count", m_count_s, sat(raw_count, CWS));
            chk("s_words", m_words_s, sat(raw_words, WW));
            chk("s_ovf", m_ovf_s, (raw_count > (2**CWS - 1)) || (raw_words > (2**WW - 1)));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_reset();
      S_Valid = 0;
      Rst = 1;
      tick();
      Rst = 0;
   endtask

   task automatic send(input logic [DW-1:0] d, input bit last, input logic [PW-1:0] p, input int gap);
      bit took = 0;
      bit done = 0;
      repeat (gap) begin
         S_Data = DW'($urandom);
         tick();
      end
      Pattern = p; S_Data = d; S_Last = last; S_Valid = 1;
      for (int n = 0; n < 100; n++) begin
         took = s_ready_a;
         tick();
         if (took) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         n_bad++;
         $display("FAIL send_timeout: S_Ready stayed low, expected acceptance at %0t", $time);
      end
      S_Valid = 0; S_Last = 0; S_Data = DW'($urandom);
   endtask

   task automatic drain(input int pct);
      bit done = 0;
      for (int n = 0; n < 200; n++) begin
         M_Ready = ($urandom_range(99) < pct);
         tick();
         if (!m_valid_a) begin
            done = 1;
            break;
         end
      end
      M_Ready = 0;
      if (!done) begin
         n_bad++;
         $display("FAIL drain_timeout: M_Valid stayed high, expected handshake at %0t", $time);
         pulse_reset();
      end
   endtask

   initial begin
      Rst = 1; S_Valid = 0; S_Last = 0; S_Data = '0; Pattern = '0; M_Ready = 0;
      tick();
      tick();
      chk_en = 1;
      Rst = 0;
      tick();
      chk("lit_reset_s_ready", s_ready_a, 1);
      chk("lit_reset_m_valid", m_valid_a, 0);
      chk("lit_reset_count", m_count_a, 0);

      // Single-beat frame
      send(8'hAA, 1, 3'b101, 0);
      chk("lit_single_valid", m_valid_a, 1);
      chk("lit_single_count", m_count_a, 3);
      chk("lit_single_words", m_words_a, 1);
      chk("lit_single_ovf", m_ovf_a, 0);
      chk("lit_single_s_ready", s_ready_a, 0);
      drain(100);

      // Straddle plus result backpressure
      send(8'hAA, 0, 3'b101, 0);
      send(8'hAA, 1, 3'b101, 0);
      repeat (5) begin
         tick();
         chk("lit_bp_count", m_count_a, 7);
         chk("lit_bp_words", m_words_a, 2);
         chk("lit_bp_s_ready", s_ready_a, 0);
         chk("lit_bp_valid", m_valid_a, 1);
      end
      M_Ready = 1;
      tick();
      chk("lit_bp_release_valid", m_valid_a, 0);
      chk("lit_bp_release_s_ready", s_ready_a, 1);
      M_Ready = 0;

      // Saturation on the narrow instance, then a clean frame
      send(8'hFF, 0, 3'b111, 0);
      send(8'hFF, 1, 3'b111, 0);
      chk("lit_sat_count", m_count_s, 7);
      chk("lit_sat_ovf", m_ovf_s, 1);
      chk("lit_sat_wide_count", m_count_a, 14);
      chk("lit_sat_wide_ovf", m_ovf_a, 0);
      drain(100);
      send(8'h00, 1, 3'b111, 0);
      chk("lit_clean_count", m_count_s, 0);
      chk("lit_clean_ovf", m_ovf_s, 0);
      drain(100);

      // Pattern change mid-frame with idle gaps
      send(8'hAA, 0, 3'b101, 0);
      Pattern = 3'b000;
      repeat (3) tick();
      send(8'hAA, 1, 3'b000, 0);
      chk("lit_patchg_count", m_count_a, 7);
      drain(100);

      // Reset mid-frame
      send(8'hAA, 0, 3'b101, 0);
      pulse_reset();
      chk("lit_rst_valid0", m_valid_a, 0);
      tick();
      chk("lit_rst_valid1", m_valid_a, 0);
      send(8'hAA, 1, 3'b101, 0);
      chk("lit_rst_count", m_count_a, 3);
      chk("lit_rst_words", m_words_a, 1);
      drain(100);

      // Randomized frames
      for (int f = 0; f < 400; f++) begin
         int nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            logic [DW-1:0] d = ($urandom_range(3) == 0) ? DW'('1) : DW'($urandom);
            if ($urandom_range(99) < 2) pulse_reset();
            send(d, b == nb - 1, PW'($urandom), $urandom_range(0, 2));
         end
         if ($urandom_range(99) < 3) pulse_reset();
         else drain(50);
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pattern_stream_counter.md
Name: pattern_stream_counter

Overview:
- Consumes a framed stream of DATA_WIDTH-bit words over a valid/ready handshake.
- Counts every occurrence of a PATTERN_WIDTH-bit pattern in the frame's bit stream, including overlapping matches and matches that straddle word boundaries.
- Emits one total per frame on a valid/ready result port.
- Sits downstream of the per-word combinational pattern counter and extends it to multi-word frames, with a register-mapped result for the AXI slave.

Parameters:
- DATA_WIDTH, 32, stream word width in bits.
- PATTERN_WIDTH, 3, pattern width in bits; legal range 2..DATA_WIDTH.
- COUNT_WIDTH, 16, width of the frame match total (saturating).
- WORDS_WIDTH, 16, width of the frame beat count (saturating).

Ports:
- Clk  in  1  rising-edge clock, only clock domain.
- Rst  in  1  synchronous reset, active-high.
- Pattern  in  PATTERN_WIDTH  pattern; sampled only on the first beat of a frame.
- S_Data  in  DATA_WIDTH  stream word; bit DATA_WIDTH-1 is first in stream order.
- S_Valid  in  1  S_Data/S_Last valid.
- S_Last  in  1  marks the final word of a frame.
- S_Ready  out  1  block can accept a beat.
- M_Count  out  COUNT_WIDTH  frame match total.
- M_Words  out  WORDS_WIDTH  number of beats in the frame.
- M_Overflow  out  1  M_Count or M_Words saturated during the frame.
- M_Valid  out  1  result valid.
- M_Ready  in  1  result consumer ready.

Behaviour:
- Reset values (Rst high at a Clk edge): state=IDLE, S_Ready=1, M_Valid=0, M_Count=0, M_Words=0, M_Overflow=0, accumulators and tail cleared. Rst overrides every other input in that cycle.
- Beat accepted when S_Valid & S_Ready at a Clk edge.
- States:
  - IDLE: no frame in progress, S_Ready=1. An accepted beat latches Pattern into a pattern register and processes the word as a first word. If S_Last=1, go to RESULT; else go to ACCUM.
  - ACCUM: S_Ready=1. Each accepted beat is processed as a continuation word. S_Last=1 goes to RESULT.
  - RESULT: S_Ready=0, M_Valid=1, outputs held stable. On M_Valid & M_Ready, go to IDLE; S_Ready=1 from the next cycle. A new frame cannot be accepted in the same cycle as the result handshake.
- Match window: window at index i compares the pattern register with V[i -: PATTERN_WIDTH].
- First word: V = S_Data; windows i = DATA_WIDTH-1 down to PATTERN_WIDTH-1, giving DATA_WIDTH-PATTERN_WIDTH+1 windows.
- Continuation word: V = {tail, S_Data}, where tail = previous accepted word[PATTERN_WIDTH-2:0]; windows i = DATA_WIDTH+PATTERN_WIDTH-2 down to PATTERN_WIDTH-1, giving DATA_WIDTH windows.
- Tail register updates on every accepted beat.
- Accumulation:
  - count += per-beat matches; words += 1.
  - Each saturates at its all-ones value.
  - Any saturation sets the sticky overflow flag, cleared at frame start.
- Result timing: M_Count, M_Words and M_Overflow include the Last beat's contribution. They become valid, with M_Valid=1, the cycle after the Last beat is accepted (latency 1).
- Pattern input changes mid-frame have no effect.
- S_Valid=0 mid-frame: the block waits indefinitely; the tail is retained.
- Reset mid-frame: partial frame discarded, tail cleared. The next accepted beat is a first word, with no straddle from pre-reset data.
- Reset while in RESULT: pending result is dropped and M_Valid goes to 0.
- Empty frames do not exist; every frame has at least one beat.

Test Plan:
- Single-beat frame. Setup: DATA_WIDTH=8, PATTERN_WIDTH=3, Pattern=3'b101. Stimulus: one beat S_Data=8'hAA, S_Last=1. Required: one cycle later M_Valid=1, M_Count=3, M_Words=1, M_Overflow=0, S_Ready=0.
- Boundary straddle. Same setup; two beats 8'hAA, 8'hAA, Last on the second. Required: M_Count=7 (3+1 straddle+3), M_Words=2.
- Result backpressure. Hold M_Ready=0 for 5 cycles after M_Valid rises. Required: M_Count/M_Words stable, S_Ready=0 throughout. One cycle after M_Ready=1, M_Valid=0 and S_Ready=1.
- Saturation. Setup: COUNT_WIDTH=3, Pattern=3'b111, beats 8'hFF, 8'hFF. Required: M_Count=7 (raw 14 saturated), M_Overflow=1. The next frame of one 8'h00 gives M_Count=0, M_Overflow=0.
- Pattern change mid-frame plus idle gaps. Stimulus: Pattern=3'b101 on beat 1 (8'hAA), then Pattern=3'b000 with 3 idle cycles, then beat 2 (8'hAA, Last). Required: M_Count=7.
- Reset mid-frame. Stimulus: accept 8'hAA (no Last), pulse Rst for 1 cycle, then send 8'hAA with Last. Required: M_Valid=0 during and after reset, final M_Count=3, M_Words=1.
